// File: rtl/led_pattern_ctrl_pkg.sv
// rtl/led_pattern_ctrl_pkg.sv - shared mode codes, bounce direction type and clog2 helper
package led_pattern_ctrl_pkg;

    localparam logic [2:0] MODE_OFF    = 3'b000;
    localparam logic [2:0] MODE_SCORE  = 3'b001;
    localparam logic [2:0] MODE_BLINK  = 3'b010;
    localparam logic [2:0] MODE_ON     = 3'b011;
    localparam logic [2:0] MODE_CHASE  = 3'b100;
    localparam logic [2:0] MODE_BOUNCE = 3'b101;
    localparam logic [2:0] MODE_BAR    = 3'b110;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Bits needed to hold values 0..value-1 (at least 1 for value <= 2).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/led_pattern_ctrl_tick_gen.sv
// rtl/led_pattern_ctrl_tick_gen.sv - pattern-step prescaler with synchronous clear
module tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    import led_pattern_ctrl_pkg::*;

    localparam int            CW   = clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap;

    assign wrap = (cnt_q == LAST);

    // A clear wins over the wrap so the cycle of a mode change never steps.
    assign tick = wrap && !clr;

    // Next prescaler count: clear, wrap to zero, or increment.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || wrap) begin
            cnt_d = '0;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - timed LED pattern generator driving the board LED bank from score or patterns
module led_pattern_ctrl #(
    parameter int WIDTH    = 7,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] score,
    input  logic [2:0]       led_control,
    output logic [WIDTH-1:0] leds_out,
    output logic             tick
);
    import led_pattern_ctrl_pkg::*;

    localparam int               PW        = clog2(WIDTH);
    localparam int               FW        = clog2(WIDTH + 1);
    localparam logic [PW-1:0]    POS_LAST  = PW'(WIDTH - 1);
    localparam logic [FW-1:0]    FILL_LAST = FW'(WIDTH);
    localparam logic [WIDTH-1:0] ONE_HOT0  = WIDTH'(1);

    logic [2:0]       mode_q,  mode_d;
    logic [PW-1:0]    pos_q,   pos_d;
    dir_e             dir_q,   dir_d;
    logic             phase_q, phase_d;
    logic [FW-1:0]    fill_q,  fill_d;
    logic [WIDTH-1:0] leds_q,  leds_d;
    logic             tick_q,  tick_d;

    logic mode_change;
    logic step;

    // Any difference restarts the pattern; re-asserting the same mode does not.
    assign mode_change = (led_control != mode_q);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (mode_change),
        .tick (step)
    );

    // Pattern state update: restart on mode change, otherwise advance only the active pattern on a step.
    always_comb begin
        mode_d  = mode_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        phase_d = phase_q;
        fill_d  = fill_q;
        tick_d  = step;
        if (mode_change) begin
            mode_d  = led_control;
            pos_d   = '0;
            dir_d   = DIR_UP;
            phase_d = 1'b1;
            fill_d  = '0;
        end else if (step) begin
            case (mode_q)
                MODE_BLINK: begin
                    phase_d = !phase_q;
                end
                MODE_CHASE: begin
                    pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
                end
                MODE_BOUNCE: begin
                    // Turn around at each end without dwelling on the end LED twice.
                    if (dir_q == DIR_UP) begin
                        if (pos_q == POS_LAST) begin
                            dir_d = DIR_DOWN;
                            pos_d = POS_LAST - PW'(1);
                        end else begin
                            pos_d = pos_q + PW'(1);
                        end
                    end else begin
                        if (pos_q == '0) begin
                            dir_d = DIR_UP;
                            pos_d = PW'(1);
                        end else begin
                            pos_d = pos_q - PW'(1);
                        end
                    end
                end
                MODE_BAR: begin
                    fill_d = (fill_q == FILL_LAST) ? '0 : fill_q + FW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Next LED frame from the post-update state, so a mode change shows its first frame immediately.
    always_comb begin
        leds_d = '0;
        case (mode_d)
            MODE_SCORE:  leds_d = score;
            MODE_BLINK:  leds_d = phase_d ? score : '0;
            MODE_ON:     leds_d = '1;
            MODE_CHASE,
            MODE_BOUNCE: leds_d = ONE_HOT0 << pos_d;
            MODE_BAR: begin
                for (int i = 0; i < WIDTH; i++) begin
                    leds_d[i] = (FW'(i) < fill_d);
                end
            end
            default:     leds_d = '0;
        endcase
    end

    // Mode, pattern state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_OFF;
            pos_q   <= '0;
            dir_q   <= DIR_UP;
            phase_q <= 1'b1;
            fill_q  <= '0;
            leds_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            fill_q  <= fill_d;
            leds_q  <= leds_d;
            tick_q  <= tick_d;
        end
    end

    assign leds_out = leds_q;
    assign tick     = tick_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - directed and randomized self-checking bench for led_pattern_ctrl
module tb_led_pattern_ctrl;
    localparam int WIDTH    = 7;
    localparam int TICK_DIV = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] score;
    logic [2:0]       led_control;
    logic [WIDTH-1:0] leds_out;
    logic             tick;

    int tests;
    int fails;

    // Reference: current mode and clock edges elapsed since it was entered.
    int               m_mode;
    int               m_cnt;
    logic [WIDTH-1:0] exp_leds;
    logic             exp_tick;

    led_pattern_ctrl #(
        .WIDTH    (WIDTH),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .score       (score),
        .led_control (led_control),
        .leds_out    (leds_out),
        .tick        (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame shown k pattern steps after entering a mode.
    function automatic logic [WIDTH-1:0] ref_frame(input int mode, input int k, input logic [WIDTH-1:0] sc);
        int p;
        logic [WIDTH-1:0] f;
        f = '0;
        case (mode)
            1: f = sc;
            2: f = (k % 2 == 0) ? sc : '0;
            3: f = '1;
            4: f = WIDTH'(1 << (k % WIDTH));
            5: begin
                p = k % (2 * WIDTH - 2);
                if (p > WIDTH - 1) p = 2 * WIDTH - 2 - p;
                f = WIDTH'(1 << p);
            end
            6: f = WIDTH'((1 << (k % (WIDTH + 1))) - 1);
            default: f = '0;
        endcase
        return f;
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // One clock edge: advance the reference, then compare both outputs.
    task automatic cyc();
        @(posedge clk);
        if (rst) begin
            m_mode   = 0;
            m_cnt    = 0;
            exp_tick = 1'b0;
            exp_leds = '0;
        end else begin
            if (int'(led_control) != m_mode) begin
                m_mode   = int'(led_control);
                m_cnt    = 0;
                exp_tick = 1'b0;
            end else begin
                m_cnt++;
                exp_tick = (m_cnt % TICK_DIV == 0);
            end
            exp_leds = ref_frame(m_mode, m_cnt / TICK_DIV, score);
        end
        #1;
        check("leds", leds_out, exp_leds);
        check("tick", {{(WIDTH-1){1'b0}}, tick}, {{(WIDTH-1){1'b0}}, exp_tick});
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        m_mode      = 0;
        m_cnt       = 0;
        rst         = 1'b1;
        score       = 7'b0100000;
        led_control = 3'b001;

        // Reset held, then SCORE.
        repeat (2) cyc();
        check("lit_reset", leds_out, 7'b0000000);
        rst = 1'b0;
        cyc();
        check("lit_score0", leds_out, 7'b0100000);
        score = 7'b0000011;
        cyc();
        check("lit_score1", leds_out, 7'b0000011);

        // ALL_ON, OFF, reserved.
        led_control = 3'b011;
        cyc();
        check("lit_on", leds_out, 7'b1111111);
        repeat (6) cyc();
        led_control = 3'b000;
        repeat (6) cyc();
        led_control = 3'b111;
        cyc();
        check("lit_rsvd", leds_out, 7'b0000000);
        repeat (9) cyc();

        // BLINK.
        score       = 7'b0100000;
        led_control = 3'b010;
        repeat (12) cyc();

        // CHASE through a full wrap.
        led_control = 3'b100;
        repeat (32) cyc();

        // BOUNCE through both ends.
        led_control = 3'b101;
        repeat (60) cyc();

        // BAR through a full wrap.
        led_control = 3'b110;
        repeat (40) cyc();

        // Restart BAR, switch to CHASE at fill=3.
        led_control = 3'b100;
        cyc();
        led_control = 3'b110;
        repeat (13) cyc();
        check("lit_bar3", leds_out, 7'b0000111);
        led_control = 3'b100;
        cyc();
        check("lit_chase_first", leds_out, 7'b0000001);
        repeat (3) cyc();
        check("lit_chase_hold", leds_out, 7'b0000001);
        cyc();
        check("lit_chase_step", leds_out, 7'b0000010);
        check("lit_chase_tick", {6'b0, tick}, 7'b0000001);
        repeat (5) cyc();

        // Asynchronous reset mid-chase, seen without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("async_leds", leds_out, 7'b0000000);
        check("async_tick", {6'b0, tick}, 7'b0000000);
        repeat (2) cyc();
        rst = 1'b0;
        repeat (10) cyc();

        // Randomized modes, scores and occasional resets.
        for (int n = 0; n < 600; n++) begin
            score = WIDTH'($urandom);
            if ($urandom_range(0, 11) == 0) led_control = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 59) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
